// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared definitions for the multi-cycle core sequencer: FSM state
//            encodings, the illegal ALU select, trap-cause codes and the PC step.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  // FSM state encodings; the numeric values are visible on state_dbg_o.
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } seq_state_e;

  // Decoder ALU select that marks an illegal / unsupported instruction.
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // Trap-cause codes.
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_INCR = 4;

endpackage : core_pkg
`default_nettype wire

// File: rtl/seq_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_wait_timer
// Brief    : Memory-request wait counter with expiry flag. Counts cycles in
//            which a request is outstanding without acknowledge; flags expiry
//            on the cycle the count would reach TIMEOUT_CYCLES. Only built
//            when SEQ_MEM_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef SEQ_MEM_TIMEOUT_EN
module seq_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255   // must be >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,       // a request is outstanding this cycle
  input  logic ack_i,       // the request completes this cycle
  output logic expired_o    // last allowed wait cycle passed without ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Expiry wins only when no ack arrives in the same cycle.
  assign expired_o = req_i & ~ack_i & (cnt_q == C_LAST);

  // Count unacknowledged request cycles; clear whenever no request is pending
  // or a request completes, so every new FETCH/MEM request starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!req_i || ack_i) begin
      cnt_q <= '0;
    end else if (!expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule : seq_wait_timer
`endif
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for a
//            single-ported core. Owns the PC and retired-instruction counter
//            and arbitrates the one memory port between fetch and load/store.
//            Optional macro SEQ_MEM_TIMEOUT_EN adds a per-request wait limit
//            (TIMEOUT_CYCLES) that traps with cause 2'b10 on expiry.
// Revision : 1.0 - initial release
// ============================================================================
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned      XLEN           = 32,
  parameter logic [XLEN-1:0]  PC_RESET       = '0,
  parameter int unsigned      TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      alu_control_i,
  input  logic            regwrite_control_i,
  input  logic            mem_read_control_i,
  input  logic            mem_write_control_i,
  input  logic            mem_ack_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic            mem_addr_sel_o,
  output logic            ir_en_o,
  output logic            regfile_we_o,
  output logic            wb_sel_o,
  output logic [XLEN-1:0] pc_o,
  output logic            retire_o,
  output logic [31:0]     instret_o,
  output logic            trap_o,
  output logic [1:0]      trap_cause_o,
  output logic [2:0]      state_dbg_o
);

  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(PC_INCR);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instret_q, instret_d;
  logic            trap_q, trap_d;
  logic [1:0]      cause_q, cause_d;

  logic            w_in_request;
  logic            w_timeout;

  // Memory port is busy exactly while waiting in FETCH or MEM.
  assign w_in_request = (state_q == ST_FETCH) || (state_q == ST_MEM);

`ifdef SEQ_MEM_TIMEOUT_EN
  seq_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .req_i     (w_in_request),
    .ack_i     (mem_ack_i),
    .expired_o (w_timeout)
  );
`else
  // No wait limit: requests stall until acknowledged, however long that takes.
  assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and strobe decode; strobes depend on state, ack and decoder.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instret_d      = instret_q;
    trap_d         = trap_q;
    cause_d        = cause_q;
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    ir_en_o        = 1'b0;
    regfile_we_o   = 1'b0;
    wb_sel_o       = 1'b0;
    retire_o       = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_en_o = 1'b1;
          state_d = ST_DECODE;
        end else if (w_timeout) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (alu_control_i == ALU_ILLEGAL) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (mem_read_control_i || mem_write_control_i) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = mem_write_control_i;
        if (mem_ack_i) begin
          // Loads still need the writeback cycle; stores are done here.
          if (mem_read_control_i) begin
            state_d = ST_WRITEBACK;
          end else begin
            retire_o = 1'b1;
            state_d  = ST_FETCH;
          end
        end else if (w_timeout) begin
          state_d = ST_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        regfile_we_o = regwrite_control_i;
        wb_sel_o     = mem_read_control_i;
        retire_o     = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (retire_o) begin
      pc_d      = pc_q + C_PC_STEP;
      instret_d = instret_q + 32'd1;
    end
  end

  // Architectural state and FSM register; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      pc_q      <= PC_RESET;
      instret_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  assign pc_o         = pc_q;
  assign instret_o    = instret_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign state_dbg_o  = state_q;

endmodule : core_sequencer
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_sequencer
// Brief    : Directed, table-driven bench for core_sequencer, plus hand-written
//            sequences for reset-during-request, illegal-instruction trap and
//            (with SEQ_MEM_TIMEOUT_EN) the memory wait limit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      alu_control;
  logic            regwrite_control;
  logic            mem_read_control;
  logic            mem_write_control;
  logic            mem_ack;
  logic            mem_req;
  logic            mem_we;
  logic            mem_addr_sel;
  logic            ir_en;
  logic            regfile_we;
  logic            wb_sel;
  logic [XLEN-1:0] pc;
  logic            retire;
  logic [31:0]     instret;
  logic            trap;
  logic [1:0]      trap_cause;
  logic [2:0]      state_dbg;

  core_sequencer #(
    .XLEN           (XLEN),
    .PC_RESET       ('0),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .alu_control_i       (alu_control),
    .regwrite_control_i  (regwrite_control),
    .mem_read_control_i  (mem_read_control),
    .mem_write_control_i (mem_write_control),
    .mem_ack_i           (mem_ack),
    .mem_req_o           (mem_req),
    .mem_we_o            (mem_we),
    .mem_addr_sel_o      (mem_addr_sel),
    .ir_en_o             (ir_en),
    .regfile_we_o        (regfile_we),
    .wb_sel_o            (wb_sel),
    .pc_o                (pc),
    .retire_o            (retire),
    .instret_o           (instret),
    .trap_o              (trap),
    .trap_cause_o        (trap_cause),
    .state_dbg_o         (state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_pc;
  logic [31:0]     exp_instret;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] alu;
    logic       rw;
    logic       rd;
    logic       wr;
    int         waits;   // wait cycles before ack on every memory access
    int         cycles;  // cycle (from FETCH entry, 1-based) holding retire
    logic       rf;      // regfile_we expected (at retire, and ever)
    logic       wb;      // wb_sel expected at retire
    logic       we;      // mem_we expected in MEM
  } vec_t;

  vec_t vecs[9];

  // Runs one instruction starting at a negedge with the FSM in FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    int       cnt = 0;
    int       retire_cyc = -1;
    int       ir_cnt = 0;
    int       addr_err = 0;
    logic     rf_seen = 1'b0;
    logic     we_seen = 1'b0;
    logic     rf_at = 1'b0;
    logic     wb_at = 1'b0;
    logic [2:0] st;
    logic [2:0] prev = 3'd7;
    string    tag;
    tag = $sformatf("v%0d", idx);
    alu_control       = v.alu;
    regwrite_control  = v.rw;
    mem_read_control  = v.rd;
    mem_write_control = v.wr;
    for (int cyc = 1; cyc <= 40 && retire_cyc < 0; cyc++) begin
      st = state_dbg;
      if (st != prev) cnt = 0;
      mem_ack = (st == 3'd1 || st == 3'd4) && (cnt == v.waits);
      cnt++;
      prev = st;
      #1;
      if (regfile_we) rf_seen = 1'b1;
      if (st == 3'd4 && mem_we) we_seen = 1'b1;
      if (ir_en) ir_cnt++;
      if ((st == 3'd1 && mem_addr_sel !== 1'b0) || (st == 3'd4 && mem_addr_sel !== 1'b1))
        addr_err++;
      if (retire) begin
        retire_cyc = cyc;
        rf_at = regfile_we;
        wb_at = wb_sel;
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    exp_pc      = exp_pc + 4;
    exp_instret = exp_instret + 1;
    check({tag, "_latency"}, 64'(retire_cyc), 64'(v.cycles));
    check({tag, "_rf_at_retire"}, 64'(rf_at), 64'(v.rf));
    check({tag, "_rf_ever"}, 64'(rf_seen), 64'(v.rf));
    check({tag, "_wb_sel"}, 64'(wb_at), 64'(v.wb));
    check({tag, "_mem_we"}, 64'(we_seen), 64'(v.we));
    check({tag, "_ir_en_pulses"}, 64'(ir_cnt), 64'd1);
    check({tag, "_addr_sel_err"}, 64'(addr_err), 64'd0);
    check({tag, "_pc"}, 64'(pc), 64'(exp_pc));
    check({tag, "_instret"}, 64'(instret), 64'(exp_instret));
    check({tag, "_next_state"}, 64'(state_dbg), 64'd1);
  endtask

  // Pulse reset across a clock edge and return at a negedge in FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_pc      = '0;
    exp_instret = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          alu    rw    rd    wr    w  cyc rf    wb    we
    vecs[0] = '{4'd0, 1'b1, 1'b0, 1'b0, 0, 4,  1'b1, 1'b0, 1'b0};  // ALU op
    vecs[1] = '{4'd2, 1'b0, 1'b0, 1'b0, 0, 4,  1'b0, 1'b0, 1'b0};  // ALU, no rd write
    vecs[2] = '{4'd0, 1'b1, 1'b1, 1'b0, 0, 5,  1'b1, 1'b1, 1'b0};  // load
    vecs[3] = '{4'd0, 1'b1, 1'b1, 1'b0, 3, 11, 1'b1, 1'b1, 1'b0};  // load, 3 waits
    vecs[4] = '{4'd0, 1'b0, 1'b0, 1'b1, 0, 4,  1'b0, 1'b0, 1'b1};  // store
    vecs[5] = '{4'd0, 1'b0, 1'b0, 1'b1, 2, 8,  1'b0, 1'b0, 1'b1};  // store, 2 waits
    vecs[6] = '{4'd5, 1'b1, 1'b0, 1'b0, 1, 5,  1'b1, 1'b0, 1'b0};  // ALU, 1 fetch wait
    vecs[7] = '{4'd0, 1'b1, 1'b0, 1'b1, 0, 4,  1'b0, 1'b0, 1'b1};  // store with rw set
    vecs[8] = '{4'hE, 1'b1, 1'b0, 1'b0, 0, 4,  1'b1, 1'b0, 1'b0};  // highest legal ALU

    rst = 1'b1;
    alu_control = '0;
    regwrite_control = 1'b0;
    mem_read_control = 1'b0;
    mem_write_control = 1'b0;
    mem_ack = 1'b0;
    exp_pc = '0;
    exp_instret = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_trap", 64'(trap), 64'd0);
    check("rst_cause", 64'(trap_cause), 64'd0);
    rst = 1'b0;
    #1;
    check("rel_state", 64'(state_dbg), 64'd0);
    check("rel_mem_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("first_req", 64'(mem_req), 64'd1);
    check("first_state", 64'(state_dbg), 64'd1);

`ifdef SEQ_MEM_TIMEOUT_EN
    // Fetch never acknowledged: traps after 4 wait cycles.
    repeat (3) @(negedge clk);
    check("to_still_fetch", 64'(state_dbg), 64'd1);
    @(negedge clk);
    check("to_state", 64'(state_dbg), 64'd6);
    check("to_trap", 64'(trap), 64'd1);
    check("to_cause", 64'(trap_cause), 64'd2);
    check("to_mem_req", 64'(mem_req), 64'd0);
    do_reset();
    // Ack on the expiry cycle wins over the timeout.
    repeat (3) @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("to_ack_wins_state", 64'(state_dbg), 64'd2);
    check("to_ack_wins_trap", 64'(trap), 64'd0);
    do_reset();
`endif

    // Table-driven instructions.
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // ALU op with mem_ack tied high: ack outside FETCH/MEM is ignored.
    begin
      logic [2:0] exp_st[4];
      exp_st[0] = 3'd1; exp_st[1] = 3'd2; exp_st[2] = 3'd3; exp_st[3] = 3'd5;
      alu_control = 4'd3;
      regwrite_control = 1'b1;
      mem_read_control = 1'b0;
      mem_write_control = 1'b0;
      mem_ack = 1'b1;
      for (int k = 0; k < 4; k++) begin
        #1;
        check($sformatf("tied_state%0d", k), 64'(state_dbg), 64'(exp_st[k]));
        check($sformatf("tied_retire%0d", k), 64'(retire), 64'(k == 3));
        check($sformatf("tied_rf_we%0d", k), 64'(regfile_we), 64'(k == 3));
        @(negedge clk);
      end
      mem_ack = 1'b0;
      exp_pc = exp_pc + 4;
      exp_instret = exp_instret + 1;
      check("tied_pc", 64'(pc), 64'(exp_pc));
      check("tied_instret", 64'(instret), 64'(exp_instret));
    end

    // Reset while a load is waiting in MEM.
    alu_control = 4'd0;
    regwrite_control = 1'b1;
    mem_read_control = 1'b1;
    mem_write_control = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("midmem_state", 64'(state_dbg), 64'd4);
    check("midmem_req", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midmem_rst_req", 64'(mem_req), 64'd0);
    check("midmem_rst_state", 64'(state_dbg), 64'd0);
    check("midmem_rst_pc", 64'(pc), 64'd0);
    check("midmem_rst_instret", 64'(instret), 64'd0);
    exp_pc = '0;
    exp_instret = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midmem_rel_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    check("midmem_req_back", 64'(mem_req), 64'd1);

    // Illegal instruction traps and stays trapped.
    alu_control = 4'hF;
    regwrite_control = 1'b1;
    mem_read_control = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("ill_decode", 64'(state_dbg), 64'd2);
    @(negedge clk);
    check("ill_state", 64'(state_dbg), 64'd6);
    check("ill_trap", 64'(trap), 64'd1);
    check("ill_cause", 64'(trap_cause), 64'd1);
    begin
      int req_seen = 0;
      int ret_seen = 0;
      int moved = 0;
      for (int k = 0; k < 100; k++) begin
        mem_ack = 1'($urandom_range(0, 1));
        alu_control = 4'($urandom_range(0, 15));
        mem_read_control = 1'($urandom_range(0, 1));
        #1;
        if (mem_req) req_seen++;
        if (retire || regfile_we || ir_en) ret_seen++;
        if (pc !== exp_pc || instret !== exp_instret || state_dbg !== 3'd6 || trap !== 1'b1)
          moved++;
        @(negedge clk);
      end
      mem_ack = 1'b0;
      check("ill_req_cycles", 64'(req_seen), 64'd0);
      check("ill_strobe_cycles", 64'(ret_seen), 64'd0);
      check("ill_state_changes", 64'(moved), 64'd0);
    end
    do_reset();
    check("ill_exit_trap", 64'(trap), 64'd0);
    check("ill_exit_cause", 64'(trap_cause), 64'd0);
    check("ill_exit_state", 64'(state_dbg), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_core_sequencer
`default_nettype wire
